// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : PC owner and fetch stage for the 16-bit instruction memory,
//               with one-entry skid buffer and execute-driven redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter int                ADDR_W    = 15,
    parameter int                DATA_W    = 16,
    parameter int                MEM_BYTES = 16384,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_rb,
    output logic [ADDR_W-1:0] mem_adrb,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    // Last halfword address doubles as the even-address / in-range mask.
    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(MEM_BYTES - 2);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_valid_q, req_valid_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [ADDR_W-1:0] if_pc_q, if_pc_d;

    logic [ADDR_W-1:0] pc_inc;

    assign mem_rb   = !rst && !stall;
    assign mem_adrb = pc_q;
    assign pc_inc   = (pc_q == PC_LAST) ? '0 : pc_q + ADDR_W'(2);

    assign if_valid = if_valid_q;
    assign if_instr = if_instr_q;
    assign if_pc    = if_pc_q;

    always_comb begin
        pc_d         = pc_q;
        req_valid_d  = mem_rb;
        req_pc_d     = mem_adrb;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;

        if (redirect) begin
            // Anything in flight or buffered belongs to the abandoned path.
            pc_d         = redirect_pc & PC_LAST;
            req_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            if_valid_d   = 1'b0;
        end else if (stall) begin
            // No issue happens while stalled, so the skid never needs a second slot.
            if (req_valid_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = mem_dout;
                skid_pc_d    = req_pc_q;
            end
        end else begin
            pc_d = pc_inc;
            if (skid_valid_q) begin
                if_valid_d   = 1'b1;
                if_instr_d   = skid_instr_q;
                if_pc_d      = skid_pc_q;
                skid_valid_d = 1'b0;
            end else begin
                if_valid_d = req_valid_q;
                if_instr_d = mem_dout;
                if_pc_d    = req_pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            req_valid_q  <= 1'b0;
            req_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
        end else begin
            pc_q         <= pc_d;
            req_valid_q  <= req_valid_d;
            req_pc_q     <= req_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit with a
//               registered-read instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [14:0] redirect_pc;
    logic        mem_rb;
    logic [14:0] mem_adrb;
    logic [15:0] mem_dout = 16'h0000;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [14:0] if_pc;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W    (15),
        .DATA_W    (16),
        .MEM_BYTES (16384),
        .RESET_PC  (15'h0000)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_rb      (mem_rb),
        .mem_adrb    (mem_adrb),
        .mem_dout    (mem_dout),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc)
    );

    // Memory content: each halfword is its own byte address XOR a fixed pattern.
    function automatic logic [15:0] word_at(input logic [14:0] a);
        return {1'b0, a} ^ 16'hBEEF;
    endfunction

    always @(posedge clk) begin
        if (mem_rb) mem_dout <= word_at(mem_adrb);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Advance one cycle, then drive this cycle's inputs and let outputs settle.
    task automatic step(input logic r, input logic s, input logic rd, input logic [14:0] rp);
        @(posedge clk);
        #1;
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rp;
        #1;
    endtask

    task automatic check_if(input string tag, input logic [14:0] pc);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        check({tag, "_pc"},    {17'd0, if_pc},    {17'd0, pc});
        check({tag, "_instr"}, {16'd0, if_instr}, {16'd0, word_at(pc)});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Reset for three cycles
        repeat (3) step(1, 0, 0, 15'h0);
        check("rst_mem_rb",   {31'd0, mem_rb},   32'd0);
        check("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check("rst_if_instr", {16'd0, if_instr}, 32'd0);
        check("rst_if_pc",    {17'd0, if_pc},    32'd0);

        // Cycles 0..4: straight-line fetch
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0, 15'h0);
            check("run_adr", {17'd0, mem_adrb}, 32'(2 * c));
            check("run_rb",  {31'd0, mem_rb},   32'd1);
            if (c >= 2) check_if("run_if", 15'(2 * (c - 2)));
            else        check("run_if_valid_lo", {31'd0, if_valid}, 32'd0);
        end

        // Cycles 5..7: stall while pc 6 is presented
        for (int c = 5; c < 8; c++) begin
            step(0, 1, 0, 15'h0);
            check("stall_rb", {31'd0, mem_rb}, 32'd0);
            check_if("stall_if", 15'd6);
        end

        // Cycles 8..11: release; skid entry 8 then 10, 12
        step(0, 0, 0, 15'h0);
        check("rel_adr", {17'd0, mem_adrb}, 32'd10);
        check_if("rel_hold", 15'd6);
        step(0, 0, 0, 15'h0);
        check_if("rel_skid", 15'd8);
        step(0, 0, 0, 15'h0);
        check_if("rel_n1", 15'd10);
        step(0, 0, 0, 15'h0);
        check_if("rel_n2", 15'd12);

        // Cycle 12 = t: redirect to odd address 0x0101
        step(0, 0, 1, 15'h0101);
        check_if("redir_t", 15'd14);
        step(0, 0, 0, 15'h0);
        check("redir_t1_adr",   {17'd0, mem_adrb}, 32'h100);
        check("redir_t1_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 15'h0);
        check("redir_t2_valid", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 15'h0);
        check_if("redir_t3", 15'h100);
        step(0, 0, 0, 15'h0);
        check_if("redir_t4", 15'h102);

        // Cycles 17..18: redirect together with stall
        step(0, 1, 1, 15'h0200);
        step(0, 1, 1, 15'h0200);
        check("rs_valid", {31'd0, if_valid}, 32'd0);
        check("rs_rb",    {31'd0, mem_rb},   32'd0);
        step(0, 0, 0, 15'h0);
        check("rs_issue_adr", {17'd0, mem_adrb}, 32'h200);
        check("rs_issue_rb",  {31'd0, mem_rb},   32'd1);
        check("rs_issue_vld", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 15'h0);
        check("rs_t2_vld", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 15'h0);
        check_if("rs_out", 15'h200);

        // Wrap at the top of memory
        step(0, 0, 1, 15'd16380);
        step(0, 0, 0, 15'h0);
        check("wrap_adr0", {17'd0, mem_adrb}, 32'd16380);
        step(0, 0, 0, 15'h0);
        check("wrap_adr1", {17'd0, mem_adrb}, 32'd16382);
        step(0, 0, 0, 15'h0);
        check("wrap_adr2", {17'd0, mem_adrb}, 32'd0);
        check_if("wrap_if0", 15'd16380);
        step(0, 0, 0, 15'h0);
        check("wrap_adr3", {17'd0, mem_adrb}, 32'd2);
        check_if("wrap_if1", 15'd16382);

        // Out-of-range redirect target gets masked
        step(0, 0, 1, 15'h7FFE);
        check_if("wrap_if2", 15'd0);
        step(0, 0, 0, 15'h0);
        check("mask_adr", {17'd0, mem_adrb}, 32'h3FFE);
        step(0, 0, 0, 15'h0);
        check("mask_next_adr", {17'd0, mem_adrb}, 32'd0);

        // Stall with skid filled, then reset mid-stall
        step(0, 1, 0, 15'h0);
        check_if("pre_rst_if", 15'h3FFE);
        step(1, 1, 0, 15'h0);
        check("rst_in_rb", {31'd0, mem_rb}, 32'd0);
        step(1, 1, 0, 15'h0);
        check("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        check("mid_rst_instr", {16'd0, if_instr}, 32'd0);
        check("mid_rst_pc",    {17'd0, if_pc},    32'd0);
        check("mid_rst_rb",    {31'd0, mem_rb},   32'd0);
        step(0, 0, 0, 15'h0);
        check("restart_adr", {17'd0, mem_adrb}, 32'd0);
        step(0, 0, 0, 15'h0);
        check("restart_vld", {31'd0, if_valid}, 32'd0);
        step(0, 0, 0, 15'h0);
        check_if("restart_if", 15'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
